soc_addr_rule_table: RTL and testbench
======================================

# soc_addr_rule_table

Runtime-programmable address-rule table and decoder for the SoC crossbar, generalising the fixed per-peripheral base/length map to NrRules entries with a configuration port, per-rule enable, lock, and a miss counter. Lookups use a valid/ready handshake. Each lookup returns, one cycle later, the index of the matching slave or a decode-miss indication. The block sits between the crossbar address path and the slave demultiplexer, and replaces constant rule arrays.

## Interface
- NrRules, 10, number of address rules (slaves); ≥1
- AddrWidth, 64, address width in bits
- IdxWidth, $clog2(NrRules) (min 1), rule index width
- RstBase, {NrRules{'0}}, per-rule base loaded at reset
- RstLength, {NrRules{'0}}, per-rule length loaded at reset
- RstValid, '1, per-rule enable loaded at reset
- CntWidth, 16, miss counter width

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- cfg_we_i  in  1  config write strobe
- cfg_idx_i  in  IdxWidth  rule to write
- cfg_base_i  in  AddrWidth  new base
- cfg_len_i  in  AddrWidth  new length
- cfg_en_i  in  1  new rule enable
- cfg_lock_i  in  1  set lock (sticky until reset)
- cfg_err_o  out  1  one-cycle pulse: write rejected
- locked_o  out  1  lock state
- req_valid_i  in  1  lookup request valid
- req_ready_o  out  1  lookup accepted when high with req_valid_i
- req_addr_i  in  AddrWidth  lookup address
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_hit_o  out  1  1 = rule matched, 0 = decode miss
- resp_idx_o  out  IdxWidth  matched rule (0 on miss)
- miss_cnt_o  out  CntWidth  saturating decode-miss count

## Operation
- Match rule i: en[i] && addr ≥ base[i] && (addr − base[i]) < len[i], with the subtraction done in AddrWidth bits. This form is overflow-free. len = 0 never matches.
- Overlap: the lowest matching index wins.
- Accept: req_valid_i && req_ready_o. The decode is evaluated against the table as it stands that cycle and registered into the response.
- req_ready_o = !resp_valid_o || resp_ready_i. This gives a single output register with pass-through back-pressure.
- Response registers hold while resp_valid_o && !resp_ready_i.
- resp_valid_o falls after a handshake with no new accept.
- Config write: on cfg_we_i, rule cfg_idx_i ← {cfg_base_i, cfg_len_i, cfg_en_i}, unless locked_o = 1 or cfg_idx_i ≥ NrRules. In either of those cases the table is unchanged and cfg_err_o pulses for the next cycle.
- cfg_lock_i sets locked_o from the next cycle on. A write in the same cycle as cfg_lock_i still takes effect.
- miss_cnt_o increments by 1 per accepted lookup that misses, and saturates at all-ones.
- Reset: table ← RstBase/RstLength/RstValid; locked_o=0, resp_valid_o=0, resp_hit_o=0, resp_idx_o=0, cfg_err_o=0, miss_cnt_o=0. req_ready_o=1 from the first cycle after reset.

## Timing
- Lookup latency: 1 cycle (accept on edge N, resp_valid_o high after edge N).
- Throughput: 1 lookup/cycle while resp_ready_i=1.
- Config write visibility: a table write on edge N affects lookups accepted on edge N+1 and later. A lookup accepted on the same edge N uses the old entry.
- cfg_err_o: high exactly one cycle, after the offending edge.
- Reset asserted mid-transaction: any pending response is discarded and resp_valid_o=0 after the reset edge. Programmed entries revert to reset values and the lock clears.
- Decode path is combinational over NrRules comparators into the response register. No state machine beyond the valid bit, the lock bit, and the counter.

## Test plan
- Reset map: RstBase = {0x8000_0000, 0x1000_0000}, RstLength = {0x4000_0000, 0x1000}; request 0x8000_0010 → resp_hit_o=1, resp_idx_o=0 one cycle after accept. Request 0x1000_0FFF → idx 1. Request 0x1000_1000 → hit=0, miss_cnt_o=1.
- Back-pressure: hold resp_ready_i=0 for 3 cycles with a response pending → req_ready_o=0 and the response stable. Release → a back-to-back stream yields 1 result/cycle in order.
- Reprogram: write rule 1 to base 0x2000_0000, len 0x80_0000 in the same cycle as a lookup of 0x2000_0000 → that lookup misses. The next lookup of 0x2000_0000 hits idx 1.
- Overlap and length edges: rules 0 and 2 both cover 0x4000_0000 → idx 0. Set len=0 on rule 0 → idx 2. Rule with base = 2^AddrWidth−0x10 and len 0x10: address all-ones hits, no wrap false-hit at 0x0.
- Lock: assert cfg_lock_i together with a write (applied). A later write → table unchanged, cfg_err_o pulses 1 cycle. cfg_idx_i = NrRules → cfg_err_o. Reset → locked_o=0.
- Counter saturation: CntWidth=4, 20 missing lookups → miss_cnt_o = 15. Reset mid-stream with resp_valid_o=1 → resp_valid_o=0 and miss_cnt_o=0 next cycle.

Source files
------------

// File: rtl/soc_addr_rule_table.sv
`default_nettype none
// ============================================================================
// Module      : soc_addr_rule_table
// Description : Runtime-programmable address-rule table and decoder. Each
//               lookup returns, one cycle after accept, the lowest-indexed
//               matching rule or a decode miss. Provides a config write port,
//               a sticky lock, and a saturating miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_addr_rule_table #(
    parameter int NR_RULES   = 10,
    parameter int ADDR_WIDTH = 64,
    parameter int IDX_WIDTH  = (NR_RULES > 1) ? $clog2(NR_RULES) : 1,
    parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] RST_BASE   = '0,
    parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] RST_LENGTH = '0,
    parameter logic [NR_RULES-1:0]                 RST_VALID  = '1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // configuration port
    input  logic                  cfg_we_i,
    input  logic [IDX_WIDTH-1:0]  cfg_idx_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_len_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_err_o,
    output logic                  locked_o,
    // lookup request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    // lookup response
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_hit_o,
    output logic [IDX_WIDTH-1:0]  resp_idx_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [NR_RULES-1:0][ADDR_WIDTH-1:0] r_base;
    logic [NR_RULES-1:0][ADDR_WIDTH-1:0] r_len;
    logic [NR_RULES-1:0]                 r_en;
    logic                                r_locked;
    logic                                r_cfg_err;
    logic                                r_resp_valid;
    logic                                r_resp_hit;
    logic [IDX_WIDTH-1:0]                r_resp_idx;
    logic [CNT_WIDTH-1:0]                r_miss_cnt;

    logic [NR_RULES-1:0]                 w_match;
    logic                                w_hit;
    logic [IDX_WIDTH-1:0]                w_idx;
    logic                                w_accept;
    logic                                w_idx_ok;
    logic                                w_cfg_reject;

    // Per-rule comparator; offset form avoids overflow at the top of the map
    for (genvar g = 0; g < NR_RULES; g++) begin : g_match
        logic [ADDR_WIDTH-1:0] w_off;
        assign w_off      = req_addr_i - r_base[g];
        assign w_match[g] = r_en[g] && (req_addr_i >= r_base[g]) && (w_off < r_len[g]);
    end

    // Priority encode: scanning downward lets the lowest matching index win
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NR_RULES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign req_ready_o  = !r_resp_valid || resp_ready_i;
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_idx_ok     = 32'(cfg_idx_i) < 32'(NR_RULES);
    assign w_cfg_reject = r_locked || !w_idx_ok;

    // Rule table, lock bit and write-error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base    <= RST_BASE;
            r_len     <= RST_LENGTH;
            r_en      <= RST_VALID;
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we_i && w_cfg_reject;
            for (int i = 0; i < NR_RULES; i++) begin
                if (cfg_we_i && !w_cfg_reject && (cfg_idx_i == IDX_WIDTH'(i))) begin
                    r_base[i] <= cfg_base_i;
                    r_len[i]  <= cfg_len_i;
                    r_en[i]   <= cfg_en_i;
                end
            end
            if (cfg_lock_i) begin
                r_locked <= 1'b1;
            end
        end
    end

    // Response register with pass-through back-pressure, plus miss counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_idx   <= '0;
            r_miss_cnt   <= '0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= w_hit;
            r_resp_idx   <= w_idx;
            if (!w_hit && (r_miss_cnt != c_cnt_max)) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end else if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign cfg_err_o    = r_cfg_err;
    assign locked_o     = r_locked;
    assign resp_valid_o = r_resp_valid;
    assign resp_hit_o   = r_resp_hit;
    assign resp_idx_o   = r_resp_idx;
    assign miss_cnt_o   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_soc_addr_rule_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_addr_rule_table
// Description : Directed bench for soc_addr_rule_table with a reference model
//               and per-cycle comparison, plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_addr_rule_table;

    localparam int N  = 10;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int CW = 4;
    localparam int CMAX = 15;
    localparam logic [N-1:0][AW-1:0] c_rst_base =
        {{8{64'h0}}, 64'h0000_0000_1000_0000, 64'h0000_0000_8000_0000};
    localparam logic [N-1:0][AW-1:0] c_rst_len =
        {{8{64'h0}}, 64'h0000_0000_0000_1000, 64'h0000_0000_4000_0000};

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we, cfg_en, cfg_lock, cfg_err;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_base, cfg_len;
    logic          locked;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid, resp_ready, resp_hit;
    logic [IW-1:0] resp_idx;
    logic [CW-1:0] miss_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    soc_addr_rule_table #(
        .NR_RULES  (N),
        .ADDR_WIDTH(AW),
        .IDX_WIDTH (IW),
        .RST_BASE  (c_rst_base),
        .RST_LENGTH(c_rst_len),
        .RST_VALID ('1),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_we_i    (cfg_we),
        .cfg_idx_i   (cfg_idx),
        .cfg_base_i  (cfg_base),
        .cfg_len_i   (cfg_len),
        .cfg_en_i    (cfg_en),
        .cfg_lock_i  (cfg_lock),
        .cfg_err_o   (cfg_err),
        .locked_o    (locked),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_hit_o  (resp_hit),
        .resp_idx_o  (resp_idx),
        .miss_cnt_o  (miss_cnt)
    );

    // ---------------- reference model ----------------
    logic [AW-1:0] m_base [N];
    logic [AW-1:0] m_len  [N];
    bit            m_en   [N];
    bit            m_locked, m_valid, m_hit, m_err;
    int            m_idx, m_cnt;

    // Address region test in wide arithmetic: base <= addr < base + len
    function automatic int find(input logic [AW-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && ({1'b0, a} >= {1'b0, m_base[i]}) &&
                ({1'b0, a} < ({1'b0, m_base[i]} + {1'b0, m_len[i]})))
                return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_base[i] <= c_rst_base[i];
                m_len[i]  <= c_rst_len[i];
                m_en[i]   <= 1'b1;
            end
            m_locked <= 0; m_valid <= 0; m_hit <= 0; m_idx <= 0; m_err <= 0; m_cnt <= 0;
        end else begin
            if (req_valid && (!m_valid || resp_ready)) begin
                m_valid <= 1;
                m_hit   <= (find(req_addr) >= 0);
                m_idx   <= (find(req_addr) >= 0) ? find(req_addr) : 0;
                if (find(req_addr) < 0) m_cnt <= (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            end else if (resp_ready) begin
                m_valid <= 0;
            end
            m_err <= cfg_we && (m_locked || int'(cfg_idx) >= N);
            if (cfg_we && !m_locked && int'(cfg_idx) < N) begin
                m_base[cfg_idx] <= cfg_base;
                m_len[cfg_idx]  <= cfg_len;
                m_en[cfg_idx]   <= cfg_en;
            end
            if (cfg_lock) m_locked <= 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_resp_valid", 64'(resp_valid), 64'(m_valid));
            chk("m_req_ready", 64'(req_ready), 64'(!m_valid || resp_ready));
            chk("m_locked", 64'(locked), 64'(m_locked));
            chk("m_cfg_err", 64'(cfg_err), 64'(m_err));
            chk("m_miss_cnt", 64'(miss_cnt), 64'(m_cnt));
            if (m_valid) begin
                chk("m_resp_hit", 64'(resp_hit), 64'(m_hit));
                chk("m_resp_idx", 64'(resp_idx), 64'(m_idx));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [AW-1:0] a);
        req_valid = 1; req_addr = a;
        step();
        req_valid = 0;
    endtask

    task automatic cfg_write(input int idx, input logic [AW-1:0] b, input logic [AW-1:0] l, input bit en);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_base = b; cfg_len = l; cfg_en = en;
        step();
        cfg_we = 0;
    endtask

    task automatic expect_resp(input string name, input bit hit, input int idx);
        chk({name, "_valid"}, 64'(resp_valid), 64'd1);
        chk({name, "_hit"}, 64'(resp_hit), 64'(hit));
        chk({name, "_idx"}, 64'(resp_idx), 64'(idx));
    endtask

    initial begin
        logic [AW-1:0] stream_addr [3];
        int            stream_idx  [3];
        bit            stream_hit  [3];
        stream_addr = '{64'h1000_0000, 64'h8000_0004, 64'h5};
        stream_idx  = '{1, 0, 0};
        stream_hit  = '{1, 1, 0};

        rst = 1; cfg_we = 0; cfg_idx = '0; cfg_base = '0; cfg_len = '0; cfg_en = 0;
        cfg_lock = 0; req_valid = 0; req_addr = '0; resp_ready = 1;
        step(); chk_en = 1;
        step();
        rst = 0;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_cnt", 64'(miss_cnt), 64'd0);
        chk("rst_idx", 64'(resp_idx), 64'd0);

        // reset map
        lookup(64'h8000_0010); expect_resp("map0", 1, 0);
        lookup(64'h1000_0FFF); expect_resp("map1", 1, 1);
        lookup(64'h1000_1000); expect_resp("mapmiss", 0, 0);
        chk("mapmiss_cnt", 64'(miss_cnt), 64'd1);
        step();
        chk("drain_valid", 64'(resp_valid), 64'd0);

        // back-pressure
        resp_ready = 0;
        req_valid = 1; req_addr = 64'h8000_0000;
        step();
        req_addr = 64'h1000_0000;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 64'(req_ready), 64'd0);
            expect_resp("bp_hold", 1, 0);
            step();
        end
        resp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_resp("stream", stream_hit[k], stream_idx[k]);
            if (k < 2) req_addr = stream_addr[k + 1];
        end
        req_valid = 0;
        chk("stream_cnt", 64'(miss_cnt), 64'd2);
        step();

        // reprogram, same-cycle lookup sees the old entry
        cfg_we = 1; cfg_idx = 4'd1; cfg_base = 64'h2000_0000; cfg_len = 64'h80_0000; cfg_en = 1;
        req_valid = 1; req_addr = 64'h2000_0000;
        step();
        cfg_we = 0; req_valid = 0;
        expect_resp("reprog_old", 0, 0);
        lookup(64'h2000_0000); expect_resp("reprog_new", 1, 1);

        // overlap and length edges
        cfg_write(0, 64'h4000_0000, 64'h1000, 1);
        cfg_write(2, 64'h3000_0000, 64'h2000_0000, 1);
        lookup(64'h4000_0000); expect_resp("overlap", 1, 0);
        cfg_write(0, 64'h4000_0000, 64'h0, 1);
        lookup(64'h4000_0000); expect_resp("len0", 1, 2);
        cfg_write(3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 1);
        lookup(64'hFFFF_FFFF_FFFF_FFFF); expect_resp("top", 1, 3);
        lookup(64'h0); expect_resp("nowrap", 0, 0);
        lookup(64'hFFFF_FFFF_FFFF_FFEF); expect_resp("below_top", 0, 0);
        chk("edge_cnt", 64'(miss_cnt), 64'd5);

        // out-of-range index
        cfg_write(N, 64'h7000_0000, 64'h100, 1);
        chk("badidx_err", 64'(cfg_err), 64'd1);
        step();
        chk("badidx_err_pulse", 64'(cfg_err), 64'd0);

        // lock with a simultaneous write
        cfg_lock = 1;
        cfg_write(4, 64'h5000_0000, 64'h100, 1);
        cfg_lock = 0;
        chk("lock_set", 64'(locked), 64'd1);
        chk("lock_err", 64'(cfg_err), 64'd0);
        cfg_write(4, 64'h6000_0000, 64'h100, 1);
        chk("locked_err", 64'(cfg_err), 64'd1);
        step();
        chk("locked_err_pulse", 64'(cfg_err), 64'd0);
        lookup(64'h5000_0010); expect_resp("locked_keep", 1, 4);
        lookup(64'h6000_0000); expect_resp("locked_new", 0, 0);
        chk("lock_cnt", 64'(miss_cnt), 64'd6);

        // counter saturation, then reset mid-stream
        req_valid = 1; req_addr = 64'h7000_0000;
        for (int k = 0; k < 20; k++) step();
        chk("sat_cnt", 64'(miss_cnt), 64'd15);
        chk("sat_valid", 64'(resp_valid), 64'd1);
        rst = 1;
        step();
        rst = 0; req_valid = 0;
        chk("midrst_valid", 64'(resp_valid), 64'd0);
        chk("midrst_cnt", 64'(miss_cnt), 64'd0);
        chk("midrst_locked", 64'(locked), 64'd0);
        lookup(64'h5000_0010); expect_resp("revert", 0, 0);
        lookup(64'h8000_0010); expect_resp("revert_map", 1, 0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
